// File: rtl/audio_frame_sched_pkg.sv
// Shared types and defaults for the audio frame scheduler (package audio_pkg).
// Holds the FSM state encoding, the sample type and the default geometry.
package audio_pkg;

    localparam int DEF_NUM_AUDIO_CHANNELS = 24;
    localparam int DEF_AUDIO_WIDTH        = 24;
    localparam int DEF_NUM_CONSUMERS      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SERVE = 2'd2,
        POP   = 2'd3
    } sched_state_t;

    typedef logic [DEF_AUDIO_WIDTH-1:0] audio_sample_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/audio_frame_sched_rr_arbiter.sv
// Round-robin selector: first set mask bit at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && mask[j]) begin
                any      = 1'b1;
                idx      = PW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_frame_sched.sv
// Serves each buffered frame to every enabled consumer in round-robin order, then pops it.
// One LATCH cycle before the first sample; stalls on the grantee's out_ready. Watchdog: AUDIO_FRAME_SCHED_TIMEOUT_EN.
module audio_frame_sched
    import audio_pkg::*;
#(
    parameter  int NUM_AUDIO_CHANNELS = DEF_NUM_AUDIO_CHANNELS,
    parameter  int AUDIO_WIDTH        = DEF_AUDIO_WIDTH,
    parameter  int NUM_CONSUMERS      = DEF_NUM_CONSUMERS,
    parameter  int TIMEOUT_CYCLES     = 64,
    localparam int CW = $clog2(NUM_AUDIO_CHANNELS),
    localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst,
    input  logic                                          buffer_ready,
    input  logic                                          buffer_full,
    input  logic [NUM_AUDIO_CHANNELS-1:0][AUDIO_WIDTH-1:0] audio_channel_in,
    output logic                                          read_enable,
    input  logic [NUM_CONSUMERS-1:0]                      consumer_en,
    output logic [NUM_CONSUMERS-1:0]                      gnt,
    output logic                                          out_valid,
    output logic [AUDIO_WIDTH-1:0]                        out_data,
    output logic [CW-1:0]                                 out_chan,
    output logic                                          out_last,
    input  logic [NUM_CONSUMERS-1:0]                      out_ready,
    output logic [15:0]                                   frame_count,
    output logic                                          overflow_seen
`ifdef AUDIO_FRAME_SCHED_TIMEOUT_EN
    ,output logic                                         timeout_seen
`endif
);

    sched_state_t state, next_state;

    logic [NUM_AUDIO_CHANNELS-1:0][AUDIO_WIDTH-1:0] frame;
    logic [NUM_CONSUMERS-1:0] pending, pend_live, pend_after, arb_mask, arb_grant, gnt_vec;
    logic [PW-1:0]            gidx, first_idx, rr_ptr, arb_ptr, arb_idx;
    logic [CW-1:0]            chan;
    logic                     arb_any, serving, xfer, last_chan, grant_done, timeout;
    logic                     pop_second, pop_done;

    assign serving    = (state == SERVE);
    assign last_chan  = (chan == CW'(NUM_AUDIO_CHANNELS - 1));
    assign xfer       = serving && out_ready[gidx];
    // A grant ends on its last transfer, when its consumer drops out, or on watchdog expiry.
    assign grant_done = serving && ((xfer && last_chan) || !consumer_en[gidx] || timeout);
    assign pend_live  = pending & consumer_en;
    assign pend_after = grant_done ? (pend_live & ~gnt_vec) : pend_live;
    assign pop_done   = !(buffer_full && !pop_second);

    always_comb begin
        gnt_vec       = '0;
        gnt_vec[gidx] = 1'b1;
    end

    assign arb_mask = (state == LATCH) ? consumer_en : pend_after;
    assign arb_ptr  = (state == LATCH) ? rr_ptr : PW'(wrap_inc(int'(gidx), NUM_CONSUMERS));

    rr_arbiter #(.N(NUM_CONSUMERS)) u_arb (
        .mask  (arb_mask),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (buffer_ready && |consumer_en) next_state = LATCH;
            LATCH:   next_state = arb_any ? SERVE : POP;
            SERVE:   if (grant_done && !arb_any) next_state = POP;
            POP:     if (pop_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        read_enable = (state == POP);
        out_valid   = serving;
        gnt         = serving ? gnt_vec : '0;
        out_data    = serving ? frame[chan] : '0;
        out_chan    = chan;
        out_last    = serving && last_chan;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame         <= '0;
            pending       <= '0;
            gidx          <= '0;
            first_idx     <= '0;
            rr_ptr        <= '0;
            chan          <= '0;
            frame_count   <= '0;
            overflow_seen <= 1'b0;
            pop_second    <= 1'b0;
        end else begin
            case (state)
                LATCH: begin
                    frame     <= audio_channel_in;
                    pending   <= consumer_en;
                    gidx      <= arb_idx;
                    first_idx <= arb_idx;
                    chan      <= '0;
                end
                SERVE: begin
                    pending <= pend_after;
                    if (grant_done) begin
                        chan <= '0;
                        if (arb_any) gidx <= arb_idx;
                    end else if (xfer) begin
                        chan <= chan + CW'(1);
                    end
                end
                POP: begin
                    // An overflowed buffer needs one read to clear the flag before the real pop.
                    pop_second <= !pop_done;
                    if (!pop_done) overflow_seen <= 1'b1;
                    if (pop_done) begin
                        frame_count <= frame_count + 16'd1;
                        rr_ptr      <= PW'(wrap_inc(int'(first_idx), NUM_CONSUMERS));
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AUDIO_FRAME_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign timeout = serving && !xfer && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tcnt         <= '0;
            timeout_seen <= 1'b0;
        end else begin
            if (state == LATCH || xfer || grant_done) tcnt <= '0;
            else if (serving)                          tcnt <= tcnt + TW'(1);
            if (timeout) timeout_seen <= 1'b1;
        end
    end
`else
    // No watchdog: a stalled grantee is waited on indefinitely.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
